// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and
// default payload/control/counter widths.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Occupancy-style encoding so the state value doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, otherwise increment until all-ones and stick there.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, asynchronously zeroed by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline register (main + skid). up_ready is decoded
// from the registered state only, so no combinational path runs from
// dn_ready back to up_ready. Also counts downstream back-pressure cycles.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl,
    input  logic              flush,
    input  logic              stall_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q,    state_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic              stallInc;

    // Next-state and payload movement; flush overrides everything and drops
    // whatever upstream offers in the same cycle.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_valid) begin
                        mainData_d = up_data;
                        mainCtrl_d = up_ctrl;
                        state_d    = HALF;
                    end
                end
                HALF: begin
                    if (up_valid && dn_ready) begin
                        mainData_d = up_data;
                        mainCtrl_d = up_ctrl;
                    end else if (up_valid) begin
                        skidData_d = up_data;
                        skidCtrl_d = up_ctrl;
                        state_d    = FULL;
                    end else if (dn_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dn_ready) begin
                        mainData_d = skidData_q;
                        mainCtrl_d = skidCtrl_q;
                        state_d    = HALF;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainCtrl_q <= '0;
            skidData_q <= '0;
            skidCtrl_q <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainCtrl_q <= mainCtrl_d;
            skidData_q <= skidData_d;
            skidCtrl_q <= skidCtrl_d;
        end
    end

    // Handshake outputs come straight from the state register; control bits
    // are masked to zero in a bubble so no spurious writes leak downstream.
    assign up_ready  = (state_q != FULL);
    assign dn_valid  = (state_q != EMPTY);
    assign dn_data   = mainData_q;
    assign dn_ctrl   = (state_q != EMPTY) ? mainCtrl_q : '0;
    assign occupancy = 2'(state_q);
    assign stallInc  = dn_valid && !dn_ready;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stallCounter (
        .clk     (clk),
        .reset   (reset),
        .inc     (stallInc),
        .clr     (stall_clr),
        .count_o (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: a driver pushes each accepted
// entry into an expected queue, a negedge monitor pops on every downstream
// transfer and checks handshake/occupancy/stall count against a counting model.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    logic              clk;
    logic              reset;
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic [CTRL_W-1:0] up_ctrl;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;
    logic [CTRL_W-1:0] dn_ctrl;
    logic              flush;
    logic              stall_clr;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    entry_t           expQ[$];
    int               occM;
    logic [CNT_W-1:0] stallM;
    int               checks;
    int               failures;

    pipe_stage_elastic #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .up_ctrl   (up_ctrl),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_data   (dn_data),
        .dn_ctrl   (dn_ctrl),
        .flush     (flush),
        .stall_clr (stall_clr),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs shortly after the clock edge and records the
    // entry as expected output if the stage will accept it at the next edge.
    task automatic applyStimulus(input logic uv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                                 input logic dr, input logic fl, input logic sc, output logic accepted);
        entry_t e;
        @(posedge clk);
        #2;
        up_valid  = uv;
        up_data   = d;
        up_ctrl   = c;
        dn_ready  = dr;
        flush     = fl;
        stall_clr = sc;
        accepted  = uv && up_ready && !fl;
        if (accepted) begin
            e.data = d;
            e.ctrl = c;
            expQ.push_back(e);
        end
    endtask

    // Monitor: at each negedge the outputs reflect the last edge and the
    // inputs are those for the next edge. Check outputs, pop on transfer,
    // then advance the counting model to the next edge.
    always @(negedge clk) begin
        entry_t e;
        int     deq;
        int     enq;
        if (reset) begin
            occM   = 0;
            stallM = '0;
        end else begin
            checkOutput("occupancy", 64'(occupancy), 64'(occM));
            checkOutput("dn_valid", 64'(dn_valid), 64'(occM != 0));
            checkOutput("up_ready", 64'(up_ready), 64'(occM < 2));
            checkOutput("stall_cnt", 64'(stall_cnt), 64'(stallM));
            if (!dn_valid) begin
                checkOutput("bubble_ctrl", 64'(dn_ctrl), 64'd0);
            end
            if (dn_valid && dn_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got data 0x%0h with nothing expected", dn_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("dn_data", 64'(dn_data), 64'(e.data));
                    checkOutput("dn_ctrl", 64'(dn_ctrl), 64'(e.ctrl));
                end
            end
            if (stall_clr) begin
                stallM = '0;
            end else if ((occM != 0) && !dn_ready && (stallM != CNT_MAX)) begin
                stallM = stallM + 1'b1;
            end
            deq = ((occM != 0) && dn_ready) ? 1 : 0;
            enq = (up_valid && (occM < 2)) ? 1 : 0;
            if (flush) begin
                occM = 0;
                expQ.delete();
            end else begin
                occM = occM - deq + enq;
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        logic acc;
        checks    = 0;
        failures  = 0;
        occM      = 0;
        stallM    = '0;
        reset     = 1'b1;
        up_valid  = 1'b0;
        up_data   = '0;
        up_ctrl   = '0;
        dn_ready  = 1'b0;
        flush     = 1'b0;
        stall_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_dn_valid", 64'(dn_valid), 64'd0);
        checkOutput("reset_dn_ctrl", 64'(dn_ctrl), 64'd0);
        checkOutput("reset_dn_data", 64'(dn_data), 64'd0);
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        reset = 1'b0;

        // Streaming with dn_ready high: one cycle latency, full throughput.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, DATA_W'(32'h11 + i), 8'h5A, 1'b1, 1'b0, 1'b0, acc);
            checkOutput("stream_accept", 64'(acc), 64'd1);
            if (i > 0) checkOutput("stream_occupancy", 64'(occupancy), 64'd1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
        checkOutput("stream_stall_cnt", 64'(stall_cnt), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Back-pressure: two entries held, third refused until drain starts.
        applyStimulus(1'b1, 32'hA, 8'h21, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hB, 8'h22, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hC, 8'h23, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("full_up_ready", 64'(up_ready), 64'd0);
        checkOutput("full_occupancy", 64'(occupancy), 64'd2);
        checkOutput("full_dn_data", 64'(dn_data), 64'hA);
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            applyStimulus(1'b1, 32'hC, 8'h23, 1'b1, 1'b0, 1'b0, acc);
        end
        checkOutput("c_accepted", 64'(acc), 64'd1);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Flush in FULL with a simultaneous offer and downstream transfer.
        applyStimulus(1'b1, 32'h31, 8'h31, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h32, 8'h32, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hD, 8'h3D, 1'b1, 1'b1, 1'b0, acc);
        checkOutput("flush_pre_occupancy", 64'(occupancy), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
        checkOutput("flush_dn_valid", 64'(dn_valid), 64'd0);
        checkOutput("flush_dn_ctrl", 64'(dn_ctrl), 64'd0);
        checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Long stall: counter must saturate, then clear wins over increment.
        applyStimulus(1'b1, 32'h44, 8'h44, 1'b0, 1'b0, 1'b0, acc);
        repeat (70000) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("stall_saturate", 64'(stall_cnt), 64'(CNT_MAX));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("stall_clear", 64'(stall_cnt), 64'd0);
        checkOutput("stall_clear_valid", 64'(dn_valid), 64'd1);

        // Asynchronous reset between edges while FULL.
        applyStimulus(1'b1, 32'h45, 8'h45, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("prereset_occupancy", 64'(occupancy), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_dn_valid", 64'(dn_valid), 64'd0);
        checkOutput("async_dn_ctrl", 64'(dn_ctrl), 64'd0);
        checkOutput("async_occupancy", 64'(occupancy), 64'd0);
        checkOutput("async_stall_cnt", 64'(stall_cnt), 64'd0);
        expQ.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Randomized traffic with occasional flush and stall clear.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom_range(1, 255)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 199) == 0), acc);
        end
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload data width (ALU result, store data, addresses packed by the instantiating stage).
REQ-002 SHALL have parameter CTRL_W, default 8, meaning control-bit width (reg_wr, mem_rd, mem_wr, mem_to_reg, etc.).
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-006 SHALL have port up_valid, input, 1 bit, meaning upstream offers an entry.
REQ-007 SHALL have port up_ready, output, 1 bit, meaning the stage accepts an entry this cycle.
REQ-008 SHALL have ports up_data and up_ctrl, input, DATA_W and CTRL_W bits, meaning the offered payload.
REQ-009 SHALL have port dn_valid, output, 1 bit, meaning the stage presents an entry.
REQ-010 SHALL have port dn_ready, input, 1 bit, meaning downstream consumes the entry.
REQ-011 SHALL have ports dn_data and dn_ctrl, output, DATA_W and CTRL_W bits, meaning the presented payload.
REQ-012 SHALL have port flush, input, 1 bit, meaning kill all held entries.
REQ-013 SHALL have port stall_clr, input, 1 bit, meaning synchronous clear of the stall counter.
REQ-014 SHALL have port occupancy, output, 2 bits, meaning the held entry count, 0 to 2.
REQ-015 SHALL have port stall_cnt, output, CNT_W bits, meaning the count of cycles with dn_valid high and dn_ready low.

Function
REQ-016 Transfer SHALL mean valid&&ready on the same edge; up_ready SHALL be decoded from registered state only (no combinational path from dn_ready).
REQ-017 States SHALL be EMPTY (occ 0), HALF (main register holds), FULL (main plus skid register hold); up_ready = (state != FULL); dn_valid = (state != EMPTY).
REQ-018 EMPTY: up_valid -> load main, go HALF; otherwise stay.
REQ-019 HALF: up_valid&dn_ready -> main <= up, stay HALF; up_valid&!dn_ready -> skid <= up, go FULL; !up_valid&dn_ready -> EMPTY; otherwise hold.
REQ-020 FULL: dn_ready -> main <= skid, go HALF; otherwise hold; no upstream accept.
REQ-021 Latency SHALL be 1 cycle from upstream transfer in EMPTY to dn_valid; sustained throughput SHALL be 1 entry/cycle with dn_ready held high.
REQ-022 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-023 dn_ctrl SHALL be all-zero whenever dn_valid=0 (bubble: no spurious reg/mem write); dn_data SHALL hold its last value when invalid.
REQ-024 flush SHALL have priority: next state EMPTY; an upstream transfer in the same cycle SHALL be discarded; a downstream transfer in the same cycle SHALL count as completed.
REQ-025 stall_cnt SHALL increment on each cycle with dn_valid&!dn_ready, saturate at all-ones, and be zeroed by stall_clr; stall_clr SHALL win over a simultaneous increment.

Reset
REQ-026 reset SHALL asynchronously force state EMPTY, main, skid, dn_data, dn_ctrl and stall_cnt to 0, occupancy to 0, dn_valid to 0, and up_ready to 1 (at the first edge after release).
REQ-027 Reset asserted mid-operation SHALL discard all held entries with no output glitch to valid.

Structure
REQ-028 A shared package pipe_pkg SHALL hold the state encoding (EMPTY=0, HALF=1, FULL=2) and the default widths.
REQ-029 The saturating counter SHALL be a sub-module named sat_counter (parameter CNT_W; inputs inc and clr).

Verification
REQ-030 Directed test 1: after reset, offer data 0x11..0x15 on consecutive cycles with dn_ready=1 -> dn_data 0x11..0x15 on consecutive cycles, each 1 cycle after its offer; occupancy=1 throughout; stall_cnt=0.
REQ-031 Directed test 2: with dn_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, up_ready=0 while 0xC is offered, occupancy=2; then dn_ready=1 -> dn_data 0xA then 0xB, then 0xC accepted.
REQ-032 Directed test 3: in FULL, assert flush together with up_valid (0xD) and dn_ready=1 -> next cycle dn_valid=0, dn_ctrl=0, occupancy=0; 0xD never appears.
REQ-033 Directed test 4: hold dn_valid=1 and dn_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt=0xFFFF; then stall_clr coinciding with a stall cycle -> stall_cnt=0.
REQ-034 Directed test 5: assert reset between edges in FULL -> dn_valid, dn_ctrl and occupancy=0 immediately, without waiting for an edge.
REQ-035 Directed test 6: random up_valid/dn_ready over 10000 cycles -> scoreboard shows strict order, no loss, and dn_ctrl=0 whenever dn_valid=0.
